// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: counters, sync/blank decode, pixel-data re-alignment.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input selecting an internal colour pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE       = 1,
  parameter int COLOR_BITS = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                                          test_mode,
`endif
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]  pix_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]  pix_y,
  output logic                                          pix_req,
  input  logic [4*COLOR_BITS-1:0]                       pix_data,
  output logic                                          line_start,
  output logic                                          frame_start,
  output logic                                          hsync,
  output logic                                          vsync,
  output logic                                          de,
  output logic [COLOR_BITS-1:0]                         red,
  output logic [COLOR_BITS-1:0]                         green,
  output logic [COLOR_BITS-1:0]                         blue,
  output logic [COLOR_BITS-1:0]                         lum
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CB    = COLOR_BITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);

  // Decode bounds are one bit wider than the counters so H_TOT-sized limits never wrap.
  localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_IDLE = (H_POL == 0);
  localparam logic VS_IDLE = (V_POL == 0);

  typedef struct packed {
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] x;
    logic       y0;
`endif
    logic       hs;
    logic       vs;
    logic       req;
  } tap_t;

  logic [DW-1:0]     r_div;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic              r_line_start;
  logic              r_frame_start;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic [4*CB-1:0]   r_rgbl;
  logic              w_pe;
  logic [HW:0]       w_hx;
  logic [VW:0]       w_vx;
  tap_t              w_raw;
  tap_t              w_tap;
  logic [4*CB-1:0]   w_src;

  assign w_pe = (r_div == DIV_LAST);
  assign w_hx = {1'b0, r_h};
  assign w_vx = {1'b0, r_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_pe ? '0 : r_div + DW'(1);
      // Pulses land in the first clk of the period that enters h==0.
      r_line_start  <= w_pe && (r_h == H_LAST);
      r_frame_start <= w_pe && (r_h == H_LAST) && (r_v == V_LAST);
      if (w_pe) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
    end
  end

  always_comb begin
    w_raw     = '0;
    w_raw.hs  = (w_hx >= H_SYNC_BEG) && (w_hx < H_SYNC_END);
    w_raw.vs  = (w_vx >= V_SYNC_BEG) && (w_vx < V_SYNC_END);
    w_raw.req = (w_hx < H_ACT_END) && (w_vx < V_ACT_END);
`ifdef VGA_TEST_PATTERN_EN
    w_raw.x   = 3'(r_h);
    w_raw.y0  = r_v[0];
`endif
  end

  generate
    if (PIPE > 1) begin : g_dly
      tap_t r_dly [PIPE-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE - 1; i++) r_dly[i] <= '0;
        end else if (w_pe) begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < PIPE - 1; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_tap = r_dly[PIPE-2];
    end else begin : g_nodly
      assign w_tap = w_raw;
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  assign w_src = test_mode ? {{CB{w_tap.x[2]}}, {CB{w_tap.x[1]}}, {CB{w_tap.x[0]}}, {CB{w_tap.y0}}}
                           : pix_data;
`else
  assign w_src = pix_data;
`endif

  // Output register: blanking forces colour to zero whatever the source presents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= HS_IDLE;
      r_vsync <= VS_IDLE;
      r_de    <= 1'b0;
      r_rgbl  <= '0;
    end else if (w_pe) begin
      r_hsync <= w_tap.hs ? ~HS_IDLE : HS_IDLE;
      r_vsync <= w_tap.vs ? ~VS_IDLE : VS_IDLE;
      r_de    <= w_tap.req;
      r_rgbl  <= w_tap.req ? w_src : '0;
    end
  end

  assign pix_x       = r_h;
  assign pix_y       = r_v;
  assign pix_req     = w_raw.req;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign red         = r_rgbl[4*CB-1:3*CB];
  assign green       = r_rgbl[3*CB-1:2*CB];
  assign blue        = r_rgbl[2*CB-1:CB];
  assign lum         = r_rgbl[CB-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small rasters (CLK_DIV=2/PIPE=2 and CLK_DIV=1/PIPE=1) with random
// pixel data, compared every clk against a period-arithmetic raster model.
module tb_vga_timing_gen;

  localparam int H_TOT = 14;
  localparam int V_TOT = 8;

  typedef struct packed {
    logic [3:0] x;
    logic [2:0] y;
    logic       req;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] rgbl;
  } obs_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] pd_a = '0, pd_b = '0;
  logic       tm_a = 1'b0, tm_b = 1'b0;
  logic [3:0] x_a, x_b;
  logic [2:0] y_a, y_b;
  logic req_a, ls_a, fs_a, hs_a, vs_a, de_a, r_a, g_a, b_a, l_a;
  logic req_b, ls_b, fs_b, hs_b, vs_b, de_b, r_b, g_b, b_b, l_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(2), .PIPE(2), .COLOR_BITS(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_a),
`endif
    .pix_x(x_a), .pix_y(y_a), .pix_req(req_a), .pix_data(pd_a),
    .line_start(ls_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .red(r_a), .green(g_a), .blue(b_a), .lum(l_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(1), .PIPE(1), .COLOR_BITS(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_b),
`endif
    .pix_x(x_b), .pix_y(y_b), .pix_req(req_b), .pix_data(pd_b),
    .line_start(ls_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .red(r_b), .green(g_b), .blue(b_b), .lum(l_b)
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int cnt_ls_a, cnt_fs_a, cnt_ls_b, cnt_fs_b;
  logic [3:0] hd_a [0:2047];
  logic [3:0] hd_b [0:2047];
  logic       ht_a [0:2047];
  logic       ht_b [0:2047];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: state index n = clks since reset release; period p = n/cd; outputs of
  // period p show coordinates of period p-pp and pixel data supplied during period p-1.
  function automatic obs_t model(input int n, input int cd, input int pp,
                                 input logic [3:0] dprev, input logic tprev);
    obs_t m;
    int p, h, v, q, hq, vq;
    logic rq;
    p = n / cd;
    h = p % H_TOT;
    v = (p / H_TOT) % V_TOT;
    m.x   = 4'(h);
    m.y   = 3'(v);
    m.req = (h < 8) && (v < 4);
    m.ls  = (n % cd == 0) && (p > 0) && (h == 0);
    m.fs  = m.ls && (v == 0);
    q = p - pp;
    if (q < 0) begin
      m.hs = 1'b1; m.vs = 1'b1; m.de = 1'b0; m.rgbl = 4'h0;
    end else begin
      hq = q % H_TOT;
      vq = (q / H_TOT) % V_TOT;
      rq = (hq < 8) && (vq < 4);
      m.hs = !((hq >= 10) && (hq < 13));
      m.vs = !((vq >= 5) && (vq < 7));
      m.de = rq;
      m.rgbl = !rq ? 4'h0 : (tprev ? {hq[2], hq[1], hq[0], vq[0]} : dprev);
    end
    return m;
  endfunction

  task automatic check_dut(input string nm, input int n, input int cd, input int pp,
                           input logic [3:0] dprev, input logic tprev, input obs_t got);
    obs_t e;
    e = model(n, cd, pp, dprev, tprev);
    check({nm, "_pix_x"},  16'(got.x),    16'(e.x));
    check({nm, "_pix_y"},  16'(got.y),    16'(e.y));
    check({nm, "_pix_req"}, 16'(got.req), 16'(e.req));
    check({nm, "_line_start"}, 16'(got.ls), 16'(e.ls));
    check({nm, "_frame_start"}, 16'(got.fs), 16'(e.fs));
    check({nm, "_hsync"},  16'(got.hs),   16'(e.hs));
    check({nm, "_vsync"},  16'(got.vs),   16'(e.vs));
    check({nm, "_de"},     16'(got.de),   16'(e.de));
    check({nm, "_rgbl"},   16'(got.rgbl), 16'(e.rgbl));
  endtask

  function automatic obs_t obs_a();
    return '{x_a, y_a, req_a, ls_a, fs_a, hs_a, vs_a, de_a, {r_a, g_a, b_a, l_a}};
  endfunction

  function automatic obs_t obs_b();
    return '{x_b, y_b, req_b, ls_b, fs_b, hs_b, vs_b, de_b, {r_b, g_b, b_b, l_b}};
  endfunction

  function automatic logic [3:0] rand_pix();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
  endfunction

  // driver: called right after release, samples on negedges, new data at each period start
  task automatic run(input int nclk);
    int pa, pb;
    cnt_ls_a = 0; cnt_fs_a = 0; cnt_ls_b = 0; cnt_fs_b = 0;
    for (int n = 0; n < nclk; n++) begin
      pa = n / 2;
      pb = n;
      check_dut("a", n, 2, 2, (pa > 0) ? hd_a[pa-1] : 4'h0, (pa > 0) ? ht_a[pa-1] : 1'b0, obs_a());
      check_dut("b", n, 1, 1, (pb > 0) ? hd_b[pb-1] : 4'h0, (pb > 0) ? ht_b[pb-1] : 1'b0, obs_b());
      cnt_ls_a += int'(ls_a); cnt_fs_a += int'(fs_a);
      cnt_ls_b += int'(ls_b); cnt_fs_b += int'(fs_b);
      if (n % 2 == 0) begin
        pd_a = rand_pix();
`ifdef VGA_TEST_PATTERN_EN
        tm_a = 1'($urandom_range(0, 1));
`endif
        hd_a[pa] = pd_a;
        ht_a[pa] = tm_a;
      end
      pd_b = rand_pix();
`ifdef VGA_TEST_PATTERN_EN
      tm_b = 1'($urandom_range(0, 1));
`endif
      hd_b[pb] = pd_b;
      ht_b[pb] = tm_b;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_dut("a_rst", 0, 2, 2, 4'h0, 1'b0, obs_a());
    check_dut("b_rst", 0, 1, 1, 4'h0, 1'b0, obs_b());
    rst_n = 1'b1;
    run($urandom_range(100, 140));

    // asynchronous reset mid-frame, checked before the next clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_dut("a_midrst", 0, 2, 2, 4'h0, 1'b0, obs_a());
    check_dut("b_midrst", 0, 1, 1, 4'h0, 1'b0, obs_b());
    @(negedge clk);
    rst_n = 1'b1;

    // 3 frames of the divided raster plus the clk that starts the 4th
    run(2 * (3 * H_TOT * V_TOT + 2));
    check("a_line_start_count",  16'(cnt_ls_a), 16'd24);
    check("a_frame_start_count", 16'(cnt_fs_a), 16'd3);
    check("b_line_start_count",  16'(cnt_ls_b), 16'd48);
    check("b_frame_start_count", 16'(cnt_fs_b), 16'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
